// File: rtl/cpu_pkg.sv
// Shared pipeline types for the EX/MEM -> MEM/WB boundary and RV32 load/store funct3 codes.
package cpu_pkg;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } ex_mem_data_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ex_mem_control_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
  } mem_wb_data_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_control_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mau_state_t;

  // Access size comes from funct3[1:0]; anything wider than a half is treated as a word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane placement and strobes for stores, lane selection and extension for loads.
module load_store_align
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half out of the returned bus word.
  always_comb begin
    byte_s = 8'h00;
    half_s = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (addr_lo)
      2'b00:   byte_s = load_word[7:0];
      2'b01:   byte_s = load_word[15:8];
      2'b10:   byte_s = load_word[23:16];
      default: byte_s = load_word[31:24];
    endcase
  end

  // Store lanes are replicated so the strobes alone decide what lands in memory.
  always_comb begin
    wdata = 32'h0000_0000;
    wstrb = 4'b0000;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << addr_lo;
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
    endcase
  end

  // Sign- or zero-extend the selected lane into a full register value.
  always_comb begin
    load_data = load_word;
    case (funct3)
      F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      F3_LH:   load_data = {{16{half_s[15]}}, half_s};
      F3_LW:   load_data = load_word;
      F3_LBU:  load_data = {24'h00_0000, byte_s};
      F3_LHU:  load_data = {16'h0000, half_s};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: passes non-memory ops straight through and runs one stalled bus transaction per load/store.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_valid,
  input  ex_mem_data_t    ex_data,
  input  ex_mem_control_t ex_control,
  output mem_wb_data_t    wb_data,
  output mem_wb_control_t wb_control,
  output logic            stall,
  output logic            bus_req,
  output logic            bus_we,
  output logic [31:0]     bus_addr,
  output logic [31:0]     bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic [31:0]     bus_rdata,
  input  logic            bus_ack,
  output logic            misalign_err,
  output logic            bus_err
);

  localparam logic [7:0] TIMEOUT_LAST_C = 8'(TIMEOUT_CYCLES - 32'd1);

  mau_state_t  state_r;
  logic [7:0]  count_r;
  logic [31:0] alu_r;
  logic [4:0]  rd_r;
  logic [2:0]  funct3_r;
  logic        reg_write_r;
  logic        mem_to_reg_r;
  logic        is_load_r;

  logic        mem_op_s;
  logic        misaligned_s;
  logic        last_wait_s;
  logic [2:0]  funct3_sel_s;
  logic [1:0]  addr_lo_sel_s;
  logic [31:0] wdata_s;
  logic [3:0]  wstrb_s;
  logic [31:0] load_data_s;

  assign mem_op_s     = ex_valid & (ex_control.mem_read | ex_control.mem_write);
  assign misaligned_s = mem_op_s & is_misaligned(ex_data.funct3, ex_data.alu_result[1:0]);
  assign last_wait_s  = (count_r == TIMEOUT_LAST_C);

  // Stores are shaped from the live EX payload at issue; loads are extended from the latched op.
  assign funct3_sel_s  = (state_r == ST_BUSY) ? funct3_r : ex_data.funct3;
  assign addr_lo_sel_s = (state_r == ST_BUSY) ? alu_r[1:0] : ex_data.alu_result[1:0];

  load_store_align u_align (
    .funct3     (funct3_sel_s),
    .addr_lo    (addr_lo_sel_s),
    .store_data (ex_data.rs2_data),
    .load_word  (bus_rdata),
    .wdata      (wdata_s),
    .wstrb      (wstrb_s),
    .load_data  (load_data_s)
  );

  // Transaction FSM: latch the op and drive the bus until ack or timeout.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      count_r      <= 8'h00;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'h0000_0000;
      bus_wdata    <= 32'h0000_0000;
      bus_wstrb    <= 4'b0000;
      alu_r        <= 32'h0000_0000;
      rd_r         <= 5'd0;
      funct3_r     <= 3'b000;
      reg_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      is_load_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_op_s && !misaligned_s) begin
            state_r      <= ST_BUSY;
            count_r      <= 8'h00;
            bus_req      <= 1'b1;
            bus_we       <= ex_control.mem_write;
            bus_addr     <= {ex_data.alu_result[31:2], 2'b00};
            bus_wdata    <= ex_control.mem_write ? wdata_s : 32'h0000_0000;
            bus_wstrb    <= ex_control.mem_write ? wstrb_s : 4'b0000;
            alu_r        <= ex_data.alu_result;
            rd_r         <= ex_data.rd;
            funct3_r     <= ex_data.funct3;
            reg_write_r  <= ex_control.reg_write;
            mem_to_reg_r <= ex_control.mem_to_reg;
            is_load_r    <= ~ex_control.mem_write;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (bus_ack || last_wait_s) begin
            state_r <= ST_IDLE;
            count_r <= 8'h00;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
          end else begin
            count_r <= count_r + 8'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Writeback view, stall and error pulses; ack takes priority over the final timeout cycle.
  always_comb begin
    wb_data      = '0;
    wb_control   = '0;
    stall        = 1'b0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;
    if (!reset) begin
      stall = 1'b0;
    end else if (state_r == ST_BUSY) begin
      wb_data.alu_result = alu_r;
      wb_data.rd         = rd_r;
      if (bus_ack) begin
        wb_data.mem_rdata     = is_load_r ? load_data_s : 32'h0000_0000;
        wb_control.reg_write  = reg_write_r & is_load_r;
        wb_control.mem_to_reg = mem_to_reg_r & is_load_r;
      end else if (last_wait_s) begin
        bus_err = 1'b1;
      end else begin
        stall = 1'b1;
      end
    end else begin
      wb_data.alu_result = ex_data.alu_result;
      wb_data.rd         = ex_data.rd;
      if (misaligned_s) begin
        misalign_err = 1'b1;
      end else if (mem_op_s) begin
        stall = 1'b1;
      end else begin
        wb_control.reg_write  = ex_valid & ex_control.reg_write;
        wb_control.mem_to_reg = ex_valid & ex_control.mem_to_reg;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized check of mem_access_unit against a size/offset arithmetic model.
module tb_mem_access_unit;
  import cpu_pkg::*;

  localparam int TO = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            ex_valid;
  ex_mem_data_t    ex_data;
  ex_mem_control_t ex_control;
  mem_wb_data_t    wb_data;
  mem_wb_control_t wb_control;
  logic            stall;
  logic            bus_req;
  logic            bus_we;
  logic [31:0]     bus_addr;
  logic [31:0]     bus_wdata;
  logic [3:0]      bus_wstrb;
  logic [31:0]     bus_rdata;
  logic            bus_ack;
  logic            misalign_err;
  logic            bus_err;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_data      (ex_data),
    .ex_control   (ex_control),
    .wb_data      (wb_data),
    .wb_control   (wb_control),
    .stall        (stall),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: everything derives from access size in bytes and byte offset.
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr % 32'd4) % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int n = size_of(f3);
    if (n == 1) return {24'h0, rs2[7:0]} * 32'h0101_0101;
    else if (n == 2) return {16'h0, rs2[15:0]} * 32'h0001_0001;
    else return rs2;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    int lanes = (1 << size_of(f3)) - 1;
    int off   = int'(addr % 32'd4);
    return 4'(lanes << off);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    int n = size_of(f3);
    int off = int'(addr % 32'd4);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = (rdata >> (8 * off)) & mask;
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic pass_op(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic mem_bits, input logic ack);
    @(posedge clock); #1;
    ex_valid              = v;
    ex_data.alu_result    = alu;
    ex_data.rs2_data      = $urandom;
    ex_data.rd            = rd;
    ex_data.funct3        = 3'b010;
    ex_control.mem_read   = ~v & mem_bits;
    ex_control.mem_write  = 1'b0;
    ex_control.reg_write  = rw;
    ex_control.mem_to_reg = m2r;
    bus_ack               = ack;
    @(negedge clock);
    chk("pt_alu", 64'(wb_data.alu_result), 64'(alu));
    chk("pt_rd", 64'(wb_data.rd), 64'(rd));
    chk("pt_mrdata", 64'(wb_data.mem_rdata), 64'h0);
    chk("pt_wbc", 64'(wb_control), 64'({v & rw, v & m2r}));
    chk("pt_stall", 64'(stall), 64'h0);
    chk("pt_merr", 64'(misalign_err), 64'h0);
    @(posedge clock); #1;
    bus_ack = 1'b0;
    @(negedge clock);
    chk("pt_noreq", 64'(bus_req), 64'h0);
  endtask

  task automatic run_mem(input bit is_store, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rdata, input int waits,
                         input logic [4:0] rd, input logic rw, input logic m2r);
    int  stalls;
    bit  ended;
    @(posedge clock); #1;
    ex_valid              = 1'b1;
    ex_data.alu_result    = addr;
    ex_data.rs2_data      = rs2;
    ex_data.rd            = rd;
    ex_data.funct3        = f3;
    ex_control.mem_read   = ~is_store;
    ex_control.mem_write  = is_store;
    ex_control.reg_write  = rw;
    ex_control.mem_to_reg = m2r;
    bus_rdata             = rdata;
    bus_ack               = 1'b0;
    if (m_misaligned(f3, addr)) begin
      @(negedge clock);
      chk("ma_err", 64'(misalign_err), 64'h1);
      chk("ma_stall", 64'(stall), 64'h0);
      chk("ma_wbc", 64'(wb_control), 64'h0);
      @(posedge clock); #1;
      ex_valid = 1'b0;
      @(negedge clock);
      chk("ma_noreq", 64'(bus_req), 64'h0);
      chk("ma_pulse", 64'(misalign_err), 64'h0);
    end else begin
      stalls = 0;
      ended  = 1'b0;
      @(negedge clock);
      chk("iss_stall", 64'(stall), 64'h1);
      chk("iss_wbc", 64'(wb_control), 64'h0);
      if (stall) stalls++;
      for (int b = 0; b < TO + 2 && !ended; b++) begin
        @(posedge clock); #1;
        bus_ack = (b == waits);
        @(negedge clock);
        chk("bus_req", 64'(bus_req), 64'h1);
        chk("bus_we", 64'(bus_we), 64'(is_store));
        chk("bus_addr", 64'(bus_addr), 64'(addr & 32'hFFFF_FFFC));
        if (is_store) begin
          chk("bus_wdata", 64'(bus_wdata), 64'(m_wdata(f3, rs2)));
          chk("bus_wstrb", 64'(bus_wstrb), 64'(m_wstrb(f3, addr)));
        end
        if (b == waits) begin
          chk("ack_stall", 64'(stall), 64'h0);
          chk("ack_berr", 64'(bus_err), 64'h0);
          chk("ack_alu", 64'(wb_data.alu_result), 64'(addr));
          chk("ack_rd", 64'(wb_data.rd), 64'(rd));
          chk("ack_mrdata", 64'(wb_data.mem_rdata), is_store ? 64'h0 : 64'(m_load(f3, addr, rdata)));
          chk("ack_wbc", 64'(wb_control), is_store ? 64'h0 : 64'({rw, m2r}));
          ended = 1'b1;
        end else if (b == TO - 1) begin
          chk("to_berr", 64'(bus_err), 64'h1);
          chk("to_stall", 64'(stall), 64'h0);
          chk("to_wbc", 64'(wb_control), 64'h0);
          ended = 1'b1;
        end else begin
          chk("wait_stall", 64'(stall), 64'h1);
          chk("wait_wbc", 64'(wb_control), 64'h0);
          chk("wait_berr", 64'(bus_err), 64'h0);
        end
        if (stall) stalls++;
      end
      chk("txn_ended", 64'(ended), 64'h1);
      chk("stall_cycles", 64'(stalls), 64'((waits < TO) ? waits + 1 : TO));
      @(posedge clock); #1;
      ex_valid = 1'b0;
      bus_ack  = 1'b0;
      @(negedge clock);
      chk("post_noreq", 64'(bus_req), 64'h0);
      chk("post_berr", 64'(bus_err), 64'h0);
    end
  endtask

  initial begin
    bit          st;
    int          k;
    logic [2:0]  f3;
    reset      = 1'b0;
    ex_valid   = 1'b0;
    ex_data.alu_result    = 32'hDEAD_BEEF;
    ex_data.rs2_data      = 32'h1234_5678;
    ex_data.rd            = 5'd9;
    ex_data.funct3        = 3'b010;
    ex_control.mem_read   = 1'b0;
    ex_control.mem_write  = 1'b0;
    ex_control.reg_write  = 1'b1;
    ex_control.mem_to_reg = 1'b0;
    bus_rdata  = 32'h0;
    bus_ack    = 1'b0;

    @(posedge clock);
    @(negedge clock);
    chk("rst_req", 64'(bus_req), 64'h0);
    chk("rst_we", 64'(bus_we), 64'h0);
    chk("rst_addr", 64'(bus_addr), 64'h0);
    chk("rst_wdata", 64'(bus_wdata), 64'h0);
    chk("rst_wstrb", 64'(bus_wstrb), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_wbc", 64'(wb_control), 64'h0);
    chk("rst_wbd", 64'(wb_data), 64'h0);
    chk("rst_errs", 64'({misalign_err, bus_err}), 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // ALU op passes through in the same cycle; bus_ack while idle is ignored.
    pass_op(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    pass_op(1'b0, 32'hCAFE_0001, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);

    // LB at 0x103, one wait cycle.
    run_mem(1'b0, F3_LB, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 1, 5'd3, 1'b1, 1'b1);
    chk("lb_const", 64'(m_load(F3_LB, 32'h103, 32'h80FF_FF00)), 64'hFFFF_FF80);
    // SH at 0x102, three waits: ack lands on the final allowed cycle and must beat the timeout.
    run_mem(1'b1, F3_SH, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 3, 5'd4, 1'b1, 1'b0);
    chk("sh_wdata_const", 64'(m_wdata(F3_SH, 32'h0000_ABCD)), 64'hABCD_ABCD);
    chk("sh_wstrb_const", 64'(m_wstrb(F3_SH, 32'h102)), 64'hC);
    // Misaligned LW, then a timed-out LW.
    run_mem(1'b0, F3_LW, 32'h0000_0101, 32'h0, 32'h0, 0, 5'd6, 1'b1, 1'b1);
    run_mem(1'b0, F3_LW, 32'h0000_0200, 32'h0, 32'h1111_2222, 100, 5'd8, 1'b1, 1'b1);
    run_mem(1'b0, F3_LHU, 32'h0000_0302, 32'h0, 32'h8765_4321, 0, 5'd10, 1'b1, 1'b1);

    // Reset asserted in the middle of a transaction.
    @(posedge clock); #1;
    ex_valid = 1'b1;
    ex_data.alu_result = 32'h0000_0404;
    ex_data.funct3 = F3_LW;
    ex_control.mem_read = 1'b1;
    ex_control.mem_write = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_stall", 64'(stall), 64'h0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("mid_rst_req", 64'(bus_req), 64'h0);
    chk("mid_rst_addr", 64'(bus_addr), 64'h0);
    chk("mid_rst_wbc", 64'(wb_control), 64'h0);
    chk("mid_rst_wbd", 64'(wb_data), 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    ex_valid = 1'b0;
    @(negedge clock);
    chk("post_rst_req", 64'(bus_req), 64'h0);
    chk("post_rst_stall", 64'(stall), 64'h0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        pass_op(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        st = ($urandom_range(0, 2) == 0);
        if (st) begin
          f3 = 3'($urandom_range(0, 2));
        end else begin
          k = $urandom_range(0, 4);
          f3 = (k == 3) ? F3_LBU : (k == 4) ? F3_LHU : 3'(k);
        end
        run_mem(st, f3, $urandom, $urandom, $urandom, $urandom_range(0, TO + 1),
                5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
